// File: rtl/fwd_scoreboard_if.sv
// fwd_scoreboard_if
// Bundles the forwarding, source-operand and multi-cycle issue signals of the
// EX-stage hazard unit.
//   master : pipeline side; drives stage write info, EX sources and MC issue
//   slave  : fwd_scoreboard; returns forward selects, stall, ready and counters
// Signal summary:
//   fwd_regwrite_i [NUM_FWD]          stage k writes a register
//   fwd_rdaddr_i   [NUM_FWD*ADDR_W]   stage k destination, k*ADDR_W +: ADDR_W
//   src_valid_i    [NUM_SRC]          source j is read by the EX instruction
//   src_addr_i     [NUM_SRC*ADDR_W]   source j address
//   forward_sel_o  [NUM_SRC*SEL_W]    0 = regfile, k+1 = forward from stage k
//   mc_issue_i / mc_rdaddr_i / mc_latency_i   multi-cycle op issue
//   mc_ready_o, stall_o, pending_count_o, stall_cycles_o
interface fwd_scoreboard_if #(
   parameter int unsigned NUM_SRC  = 2,
   parameter int unsigned NUM_FWD  = 2,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned NUM_PEND = 4,
   parameter int unsigned CNT_W    = 4
);
   localparam int unsigned SEL_W = $clog2(NUM_FWD + 1);
   localparam int unsigned PC_W  = $clog2(NUM_PEND + 1);

   logic [NUM_FWD-1:0]        fwd_regwrite_i;
   logic [NUM_FWD*ADDR_W-1:0] fwd_rdaddr_i;
   logic [NUM_SRC-1:0]        src_valid_i;
   logic [NUM_SRC*ADDR_W-1:0] src_addr_i;
   logic [NUM_SRC*SEL_W-1:0]  forward_sel_o;
   logic                      mc_issue_i;
   logic [ADDR_W-1:0]         mc_rdaddr_i;
   logic [CNT_W-1:0]          mc_latency_i;
   logic                      mc_ready_o;
   logic                      stall_o;
   logic [PC_W-1:0]           pending_count_o;
   logic [15:0]               stall_cycles_o;

   modport master (
      output fwd_regwrite_i, fwd_rdaddr_i, src_valid_i, src_addr_i,
             mc_issue_i, mc_rdaddr_i, mc_latency_i,
      input  forward_sel_o, mc_ready_o, stall_o, pending_count_o, stall_cycles_o
   );

   modport slave (
      input  fwd_regwrite_i, fwd_rdaddr_i, src_valid_i, src_addr_i,
             mc_issue_i, mc_rdaddr_i, mc_latency_i,
      output forward_sel_o, mc_ready_o, stall_o, pending_count_o, stall_cycles_o
   );
endinterface

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard
// EX-stage operand forwarding plus a small scoreboard of in-flight multi-cycle
// (MUL/DIV) destinations. Forward selects, stall and issue-ready are
// combinational from inputs and registered scoreboard state; the scoreboard and
// the saturating stall-cycle counter update on the rising edge.
// Ports:
//   clk_i  rising-edge clock
//   rst_i  synchronous active-high reset (drops all in-flight entries)
//   bus    fwd_scoreboard_if.slave (see interface header for signal list)
module fwd_scoreboard #(
   parameter int unsigned NUM_SRC  = 2,
   parameter int unsigned NUM_FWD  = 2,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned NUM_PEND = 4,
   parameter int unsigned CNT_W    = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   fwd_scoreboard_if.slave   bus
);
   localparam int unsigned SEL_W = $clog2(NUM_FWD + 1);
   localparam int unsigned PC_W  = $clog2(NUM_PEND + 1);

   logic [NUM_PEND-1:0] ent_valid;
   logic [ADDR_W-1:0]   ent_rd  [NUM_PEND];
   logic [CNT_W-1:0]    ent_cnt [NUM_PEND];
   logic [15:0]         stall_cnt;

   logic [NUM_SRC*SEL_W-1:0] sel_flat;
   logic [ADDR_W-1:0]        fwd_src;
   logic [ADDR_W-1:0]        sb_src;
   logic [ADDR_W-1:0]        stg_rd;
   logic                     full;
   logic                     waw;
   logic                     stall;
   logic                     ready;
   logic                     accept;
   logic                     alloc_found;
   logic [NUM_PEND-1:0]      alloc_oh;
   logic [PC_W-1:0]          pend_cnt;
   logic [CNT_W-1:0]         lat_eff;

   // Stages are scanned from oldest to youngest so the youngest candidate
   // (lowest index) is the last assignment and wins.
   always_comb begin
      sel_flat = '0;
      fwd_src  = '0;
      stg_rd   = '0;
      for (int unsigned j = 0; j < NUM_SRC; j++) begin
         fwd_src = bus.src_addr_i[j*ADDR_W +: ADDR_W];
         if (bus.src_valid_i[j] && fwd_src != '0) begin
            for (int unsigned k = NUM_FWD; k > 0; k--) begin
               stg_rd = bus.fwd_rdaddr_i[(k-1)*ADDR_W +: ADDR_W];
               if (bus.fwd_regwrite_i[k-1] && stg_rd != '0 && stg_rd == fwd_src)
                  sel_flat[j*SEL_W +: SEL_W] = SEL_W'(k);
            end
         end
      end
   end

   // Scoreboard lookups use current state only: an entry retiring this cycle
   // still stalls and still blocks a WAW re-issue.
   always_comb begin
      full        = &ent_valid;
      waw         = 1'b0;
      stall       = 1'b0;
      pend_cnt    = '0;
      alloc_oh    = '0;
      alloc_found = 1'b0;
      sb_src      = '0;
      for (int unsigned i = 0; i < NUM_PEND; i++) begin
         if (ent_valid[i] && bus.mc_rdaddr_i != '0 && ent_rd[i] == bus.mc_rdaddr_i)
            waw = 1'b1;
         if (!ent_valid[i] && !alloc_found) begin
            alloc_oh[i] = 1'b1;
            alloc_found = 1'b1;
         end
         pend_cnt = pend_cnt + PC_W'(ent_valid[i]);
         for (int unsigned j = 0; j < NUM_SRC; j++) begin
            sb_src = bus.src_addr_i[j*ADDR_W +: ADDR_W];
            if (ent_valid[i] && bus.src_valid_i[j] && sb_src != '0 && ent_rd[i] == sb_src)
               stall = 1'b1;
         end
      end
   end

   assign ready   = !full && !waw;
   // rd = x0 issues are accepted but never tracked.
   assign accept  = bus.mc_issue_i && ready && (bus.mc_rdaddr_i != '0);
   assign lat_eff = (bus.mc_latency_i == '0) ? CNT_W'(1) : bus.mc_latency_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ent_valid <= '0;
         stall_cnt <= '0;
         for (int unsigned i = 0; i < NUM_PEND; i++) begin
            ent_rd[i]  <= '0;
            ent_cnt[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_PEND; i++) begin
            // alloc_oh only ever marks a currently free entry, so allocation
            // and retirement never target the same slot.
            if (accept && alloc_oh[i]) begin
               ent_valid[i] <= 1'b1;
               ent_rd[i]    <= bus.mc_rdaddr_i;
               ent_cnt[i]   <= lat_eff;
            end else if (ent_valid[i]) begin
               if (ent_cnt[i] == CNT_W'(1))
                  ent_valid[i] <= 1'b0;
               ent_cnt[i] <= ent_cnt[i] - CNT_W'(1);
            end
         end
         if (stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + 16'd1;
      end
   end

   assign bus.forward_sel_o   = sel_flat;
   assign bus.mc_ready_o      = ready;
   assign bus.stall_o         = stall;
   assign bus.pending_count_o = pend_cnt;
   assign bus.stall_cycles_o  = stall_cnt;
endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard
// Directed stimulus pushes hand-computed expectations into a queue; a monitor
// on the falling edge pops and compares them against the DUT outputs.
module tb_fwd_scoreboard;
   localparam int unsigned NUM_SRC  = 2;
   localparam int unsigned NUM_FWD  = 2;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned NUM_PEND = 4;
   localparam int unsigned CNT_W    = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fwd_scoreboard_if #(
      .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .ADDR_W(ADDR_W),
      .NUM_PEND(NUM_PEND), .CNT_W(CNT_W)
   ) bus ();

   fwd_scoreboard #(
      .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .ADDR_W(ADDR_W),
      .NUM_PEND(NUM_PEND), .CNT_W(CNT_W)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   typedef enum int {F_SEL0, F_SEL1, F_STALL, F_READY, F_PEND, F_SCNT} fld_e;
   typedef struct {
      string       name;
      fld_e        fld;
      int unsigned exp;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   task automatic expect_val(input string name, input fld_e fld, input int unsigned exp);
      exp_t e;
      e.name = name;
      e.fld  = fld;
      e.exp  = exp;
      exp_q.push_back(e);
   endtask

   function automatic int unsigned actual(input fld_e fld);
      case (fld)
         F_SEL0:  return 32'(bus.forward_sel_o[1:0]);
         F_SEL1:  return 32'(bus.forward_sel_o[3:2]);
         F_STALL: return 32'(bus.stall_o);
         F_READY: return 32'(bus.mc_ready_o);
         F_PEND:  return 32'(bus.pending_count_o);
         default: return 32'(bus.stall_cycles_o);
      endcase
   endfunction

   // Monitor
   initial begin
      exp_t        e;
      int unsigned got;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = actual(e.fld);
            n_tests++;
            if (got !== e.exp) begin
               n_fail++;
               $display("FAIL %s: got %0d expected %0d (t=%0t)", e.name, got, e.exp, $time);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_fwd(input logic [1:0] rw, input logic [4:0] rd1, input logic [4:0] rd0);
      bus.fwd_regwrite_i = rw;
      bus.fwd_rdaddr_i   = {rd1, rd0};
   endtask

   task automatic set_src(input logic [1:0] v, input logic [4:0] a1, input logic [4:0] a0);
      bus.src_valid_i = v;
      bus.src_addr_i  = {a1, a0};
   endtask

   task automatic issue(input logic en, input logic [4:0] rd, input logic [3:0] lat);
      bus.mc_issue_i   = en;
      bus.mc_rdaddr_i  = rd;
      bus.mc_latency_i = lat;
   endtask

   // Stimulus
   initial begin
      set_fwd(2'b00, 5'd0, 5'd0);
      set_src(2'b00, 5'd0, 5'd0);
      issue(1'b0, 5'd0, 4'd0);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      expect_val("rst_pend",  F_PEND,  0);
      expect_val("rst_scnt",  F_SCNT,  0);
      expect_val("rst_ready", F_READY, 1);
      expect_val("rst_stall", F_STALL, 0);
      cyc();

      // Forward priority
      set_fwd(2'b11, 5'd5, 5'd5);
      set_src(2'b01, 5'd0, 5'd5);
      expect_val("prio_both",  F_SEL0, 1);
      expect_val("prio_src1",  F_SEL1, 0);
      cyc();
      set_fwd(2'b10, 5'd5, 5'd5);
      expect_val("prio_stage1", F_SEL0, 2);
      cyc();
      set_src(2'b01, 5'd0, 5'd0);
      expect_val("prio_src_x0", F_SEL0, 0);
      cyc();

      // x0 and invalid sources
      set_fwd(2'b01, 5'd0, 5'd0);
      set_src(2'b01, 5'd0, 5'd0);
      expect_val("x0_stage", F_SEL0, 0);
      cyc();
      set_fwd(2'b01, 5'd0, 5'd7);
      set_src(2'b00, 5'd7, 5'd0);
      expect_val("inv_sel1",  F_SEL1,  0);
      expect_val("inv_stall", F_STALL, 0);
      cyc();
      set_src(2'b10, 5'd7, 5'd0);
      expect_val("val_sel1", F_SEL1, 1);
      cyc();
      set_fwd(2'b10, 5'd7, 5'd3);
      set_src(2'b11, 5'd7, 5'd3);
      expect_val("s1_only_sel1", F_SEL1, 2);
      expect_val("s1_only_sel0", F_SEL0, 0);
      cyc();

      // Multi-cycle stall: issue rd=9 lat 3
      set_fwd(2'b00, 5'd0, 5'd0);
      set_src(2'b01, 5'd0, 5'd9);
      issue(1'b1, 5'd9, 4'd3);
      expect_val("mc_c0_stall", F_STALL, 0);
      expect_val("mc_c0_ready", F_READY, 1);
      cyc();
      issue(1'b0, 5'd0, 4'd0);
      expect_val("mc_c1_stall", F_STALL, 1);
      expect_val("mc_c1_pend",  F_PEND,  1);
      expect_val("mc_c1_scnt",  F_SCNT,  0);
      cyc();
      set_fwd(2'b01, 5'd0, 5'd9);
      expect_val("mc_c2_stall", F_STALL, 1);
      expect_val("mc_c2_sel0",  F_SEL0,  1);
      expect_val("mc_c2_scnt",  F_SCNT,  1);
      cyc();
      set_fwd(2'b00, 5'd0, 5'd0);
      expect_val("mc_c3_stall", F_STALL, 1);
      expect_val("mc_c3_pend",  F_PEND,  1);
      cyc();
      expect_val("mc_c4_stall", F_STALL, 0);
      expect_val("mc_c4_pend",  F_PEND,  0);
      expect_val("mc_c4_scnt",  F_SCNT,  3);
      cyc();

      // Full / WAW / x0 issue / latency 0 / retire-reissue
      set_src(2'b00, 5'd0, 5'd0);
      issue(1'b1, 5'd1, 4'd4);
      cyc();
      issue(1'b1, 5'd2, 4'd12);
      cyc();
      issue(1'b1, 5'd3, 4'd12);
      cyc();
      issue(1'b1, 5'd4, 4'd12);
      expect_val("fill_ready", F_READY, 1);
      cyc();
      issue(1'b0, 5'd5, 4'd0);
      expect_val("full_ready_retiring", F_READY, 0);
      expect_val("full_pend",           F_PEND,  4);
      cyc();
      expect_val("after_retire_ready", F_READY, 1);
      expect_val("after_retire_pend",  F_PEND,  3);
      cyc();
      issue(1'b0, 5'd2, 4'd0);
      expect_val("waw_ready", F_READY, 0);
      cyc();
      issue(1'b1, 5'd0, 4'd5);
      expect_val("x0_issue_ready", F_READY, 1);
      expect_val("x0_issue_pend",  F_PEND,  3);
      cyc();
      issue(1'b1, 5'd5, 4'd0);
      expect_val("x0_after_pend", F_PEND,  3);
      expect_val("lat0_ready",    F_READY, 1);
      cyc();
      issue(1'b0, 5'd6, 4'd0);
      set_src(2'b01, 5'd0, 5'd5);
      expect_val("lat0_full_ready", F_READY, 0);
      expect_val("lat0_pend",       F_PEND,  4);
      expect_val("lat0_stall",      F_STALL, 1);
      cyc();
      expect_val("lat0_gone_pend",  F_PEND,  3);
      expect_val("lat0_gone_stall", F_STALL, 0);
      cyc();
      set_src(2'b00, 5'd0, 5'd0);
      cyc();
      cyc();
      issue(1'b1, 5'd2, 4'd2);
      expect_val("reissue_retiring_ready", F_READY, 0);
      cyc();
      expect_val("reissue_next_ready", F_READY, 1);
      expect_val("reissue_next_pend",  F_PEND,  2);
      cyc();
      issue(1'b0, 5'd0, 4'd0);
      expect_val("reissue_c15_pend", F_PEND, 2);
      cyc();
      expect_val("reissue_c16_pend", F_PEND, 1);
      cyc();
      expect_val("drain_pend",  F_PEND,  0);
      expect_val("drain_ready", F_READY, 1);
      cyc();

      // Reset mid-flight
      issue(1'b1, 5'd11, 4'd10);
      cyc();
      issue(1'b1, 5'd12, 4'd10);
      cyc();
      issue(1'b0, 5'd0, 4'd0);
      set_src(2'b01, 5'd0, 5'd11);
      expect_val("pre_rst_pend",  F_PEND,  2);
      expect_val("pre_rst_stall", F_STALL, 1);
      cyc();
      rst = 1'b1;
      issue(1'b1, 5'd13, 4'd5);
      cyc();
      rst = 1'b0;
      issue(1'b0, 5'd11, 4'd0);
      expect_val("mid_rst_pend",  F_PEND,  0);
      expect_val("mid_rst_stall", F_STALL, 0);
      expect_val("mid_rst_ready", F_READY, 1);
      expect_val("mid_rst_scnt",  F_SCNT,  0);
      cyc();
      expect_val("mid_rst_discard_pend", F_PEND, 0);
      cyc();

      // Saturation: rd 9/10 alternately re-issued so one is always pending
      set_src(2'b11, 5'd10, 5'd9);
      for (int i = 0; i < 70000; i++) begin
         issue(1'b1, (i % 2 == 0) ? 5'd9 : 5'd10, 4'd15);
         cyc();
      end
      issue(1'b1, 5'd9, 4'd15);
      expect_val("sat_scnt",  F_SCNT,  32'hFFFF);
      expect_val("sat_stall", F_STALL, 1);
      cyc();
      issue(1'b1, 5'd10, 4'd15);
      expect_val("sat_nowrap", F_SCNT, 32'hFFFF);
      cyc();
      issue(1'b0, 5'd0, 4'd0);
      set_src(2'b00, 5'd0, 5'd0);
      cyc();

      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised operand-forwarding and hazard unit for the EX stage of the pipelined RISC-V core. It generalises two-stage forwarding to any number of source operands and forwarding stages. It adds a small scoreboard that tracks destination registers of in-flight multi-cycle operations (MUL/DIV) and raises a stall when an EX source depends on one. A saturating stall-cycle counter is included for performance monitoring.

## Interface
- NUM_SRC, 2, number of EX source operands checked
- NUM_FWD, 2, number of forwarding stages; index 0 = youngest (EX/MEM), highest priority
- ADDR_W, 5, register address width
- NUM_PEND, 4, scoreboard entries
- CNT_W, 4, multi-cycle latency counter width
- SEL_W, derived = clog2(NUM_FWD+1), forward select width

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- fwd_regwrite_i  in  NUM_FWD  stage k writes a register
- fwd_rdaddr_i  in  NUM_FWD*ADDR_W  stage k destination, stage k in bits [k*ADDR_W +: ADDR_W]
- src_valid_i  in  NUM_SRC  source j is actually read by the EX instruction
- src_addr_i  in  NUM_SRC*ADDR_W  source j address
- forward_sel_o  out  NUM_SRC*SEL_W  per source: 0 = register file, k+1 = forward from stage k
- mc_issue_i  in  1  multi-cycle op issues this cycle
- mc_rdaddr_i  in  ADDR_W  its destination
- mc_latency_i  in  CNT_W  cycles until its result is in the forwarding path
- mc_ready_o  out  1  scoreboard can accept an issue
- stall_o  out  1  EX must hold
- pending_count_o  out  clog2(NUM_PEND+1)  valid scoreboard entries
- stall_cycles_o  out  16  saturating count of cycles with stall_o=1

## Operation
- Forwarding is combinational per source j:
  - Candidate stage k: fwd_regwrite_i[k]=1, fwd_rdaddr_i[k]!=0, and fwd_rdaddr_i[k]==src_addr_i[j].
  - Lowest-index candidate wins: sel = k+1.
  - No candidate, src_valid_i[j]=0, or src_addr_i[j]=0: sel = 0.
- Scoreboard entry: valid, rd[ADDR_W], cnt[CNT_W].
- Issue is accepted when mc_issue_i & mc_ready_o.
  - On acceptance with mc_rdaddr_i!=0: allocate the lowest-index free entry, cnt = max(mc_latency_i, 1).
  - With mc_rdaddr_i=0: accepted, nothing allocated.
- Each cycle every valid entry decrements cnt. An entry with cnt==1 clears at that edge. An op issued with latency L is therefore pending for exactly L cycles after the issue edge.
- mc_ready_o = 0 when all NUM_PEND entries are valid, or when mc_rdaddr_i!=0 matches a valid entry's rd (WAW). Otherwise 1.
  - Evaluated on current state only. A retirement in the same cycle does not raise ready.
- stall_o = 1 when any source j has src_valid_i[j]=1, src_addr_i[j]!=0, and src_addr_i[j] equal to a valid entry's rd.
  - Stall takes precedence: forward_sel_o is still driven, but EX must ignore it while stalled.
  - An entry retiring this cycle still stalls this cycle.
- stall_cycles_o increments on every edge with stall_o=1 and saturates at 0xFFFF.
- pending_count_o is the population count of valid entries.

## Timing
- forward_sel_o, stall_o and mc_ready_o are combinational from inputs and registered scoreboard state. No latency on forwarding.
- The scoreboard, pending_count_o and stall_cycles_o update on the rising edge.
- Reset (synchronous, rst_i=1 at edge):
  - All entries invalid; pending_count_o=0; stall_cycles_o=0.
  - After that edge: mc_ready_o=1, stall_o=0.
  - forward_sel_o follows its combinational inputs regardless of reset.
- Reset mid-operation: all in-flight entries are dropped at that edge. An issue presented in the reset cycle is discarded.
- Simultaneous issue and retirement of different entries in one cycle: both take effect at the same edge.
- Re-issue to an rd retiring this cycle: rejected this cycle (WAW against current state); accepted next cycle.
- Latency wrap: mc_latency_i=0 behaves as 1. The maximum latency is 2^CNT_W-1.

## Test plan
- Forward priority: NUM_FWD=2; stage0 rd=5 write, stage1 rd=5 write; src0=5 valid -> sel0=1. Drop stage0 regwrite -> sel0=2. Set src0=0 -> sel0=0.
- x0 and invalid sources: stage0 rd=0 write, src0=0 -> sel0=0. src1=7 with src_valid_i[1]=0 and stage0 rd=7 -> sel1=0, stall_o=0.
- Multi-cycle stall: issue rd=9, latency 3 at cycle 0. src0=9 valid -> stall_o=1 in cycles 1..3, 0 in cycle 4. stall_cycles_o=3 at that point; pending_count_o goes 1 then back to 0.
- Full/WAW: NUM_PEND=4; issue rd=1..4, latency 8. mc_ready_o=0 for rd=5 (full). After one retirement, mc_ready_o=1 for rd=5 but 0 for rd=2 (WAW). Issue rd=0 while not full -> accepted, pending_count_o unchanged.
- Reset mid-flight: two entries pending, assert rst_i one cycle -> next cycle pending_count_o=0, stall_o=0, mc_ready_o=1, stall_cycles_o=0.
- Saturation: hold a dependent source for 70000 stalled cycles with latency re-issued continuously -> stall_cycles_o=0xFFFF, no wrap.
